// File: rtl/serial_adder_if.sv
// Host-side handshake and operand/result bundle for serial_adder_ctrl.
// master = host block, slave = the bit-serial adder controller.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start,
        output a,
        output b,
        output cin,
        input  ready,
        input  busy,
        input  done,
        input  sum,
        input  cout,
        input  ovf
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  cin,
        output ready,
        output busy,
        output done,
        output sum,
        output cout,
        output ovf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder stepped LSB-first over WIDTH cycles.
// Optional signed-overflow flag enabled by macro SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_q;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             run;
    logic             last;

    assign accept = (state == S_IDLE) && bus.start;
    assign run    = (state == S_RUN);
    assign last   = run && (cnt == LAST);

    assign fa_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_c = (a_sh[0] & b_sh[0])
                | (a_sh[0] & carry)
                | (b_sh[0] & carry);

    // New sum bit enters at the MSB; written this way so WIDTH=1 works
    always_comb begin
        sum_sh            = sum_q >> 1;
        sum_sh[WIDTH-1]   = fa_s;
    end

    // Next-state decode: IDLE -> RUN on start, RUN -> DONE after last bit
    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == S_IDLE): if (bus.start) state_nxt = S_RUN;
            (state == S_RUN):  if (cnt == LAST) state_nxt = S_DONE;
            (state == S_DONE): state_nxt = S_IDLE;
            default:           state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand shifters, carry flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
        end else if (run) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers: cleared on accept, built during RUN, then held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (run) begin
            sum_q <= sum_sh;
            if (last) cout_q <= fa_c;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into MSB differs from carry out of MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= carry ^ fa_c;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.ready = (state == S_IDLE);
    assign bus.busy  = run;
    assign bus.done  = (state == S_DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
// Expected ovf depends on whether SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;
`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Called at a negedge with ready=1; returns at the first ready negedge
    task automatic run8(input string tag,
                        input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic, input logic [7:0] es,
                        input logic ec, input logic eo);
        int lat;
        lat = 0;
        bus8.start = 1'b1;
        bus8.a = ia;
        bus8.b = ib;
        bus8.cin = ic;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus8.start = 1'b0;
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            if (k == 1) check({tag, "_busy"}, 32'(bus8.busy), 32'd1);
            if (bus8.done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_sum"}, 32'(bus8.sum), 32'(es));
        check({tag, "_cout"}, 32'(bus8.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(bus8.ovf), 32'(eo & OVF_ON));
        @(negedge clk);
        check({tag, "_ready"}, 32'(bus8.ready), 32'd1);
        check({tag, "_hold"}, 32'(bus8.sum), 32'(es));
    endtask

    task automatic run1(input int idx, input logic [1:0] exp);
        int lat;
        lat = 0;
        bus1.start = 1'b1;
        bus1.a = idx[2];
        bus1.b = idx[1];
        bus1.cin = idx[0];
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus1.start = 1'b0;
            if (bus1.done) begin
                lat = k;
                break;
            end
        end
        check($sformatf("w1_%0d_lat", idx), 32'(lat), 32'd2);
        check($sformatf("w1_%0d_res", idx),
              32'({bus1.cout, bus1.sum}), 32'(exp));
        @(negedge clk);
        check($sformatf("w1_%0d_ready", idx), 32'(bus1.ready), 32'd1);
    endtask

    logic [1:0] w1_exp [8];
    int         n_done;

    initial begin
        n_chk = 0;
        n_pass = 0;
        w1_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
        bus8.start = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus8.cin = 1'b0;
        bus1.start = 1'b0;
        bus1.a = '0;
        bus1.b = '0;
        bus1.cin = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus8.ready), 32'd1);
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_done", 32'(bus8.done), 32'd0);
        check("rst_sum", 32'(bus8.sum), 32'd0);
        check("rst_cout", 32'(bus8.cout), 32'd0);
        check("rst_ovf", 32'(bus8.ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run8("basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        run8("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("ff00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run8("cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

        // Start during RUN must be ignored
        n_done = 0;
        bus8.start = 1'b1;
        bus8.a = 8'h10;
        bus8.b = 8'h20;
        bus8.cin = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            bus8.start = (k == 3);
            bus8.a = 8'h01;
            bus8.b = 8'h01;
            if (bus8.done) n_done++;
        end
        check("ign_sum", 32'(bus8.sum), 32'h30);
        check("ign_ndone", 32'(n_done), 32'd1);
        check("ign_ready", 32'(bus8.ready), 32'd1);

        // Asynchronous reset in the middle of RUN
        n_done = 0;
        bus8.start = 1'b1;
        bus8.a = 8'hAA;
        bus8.b = 8'h55;
        bus8.cin = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus8.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(bus8.busy), 32'd0);
        check("mrst_ready", 32'(bus8.ready), 32'd1);
        check("mrst_sum", 32'(bus8.sum), 32'd0);
        check("mrst_cout", 32'(bus8.cout), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus8.done) n_done++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus8.done) n_done++;
        end
        check("mrst_ndone", 32'(n_done), 32'd0);
        run8("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        run8("ovf_7f", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("ovf_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run8("ovf_10", 8'h10, 8'h10, 1'b0, 8'h20, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) run1(i, w1_exp[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It sequences a single 1-bit full-adder datapath over WIDTH cycles to add two WIDTH-bit operands, LSB first.
- Start/ready/done handshake for a host block.
- Result registers hold the sum and carry-out stable until the next accepted start.
- Trades latency for area in place of a WIDTH-bit ripple adder.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
ready  output  1  high in IDLE only
busy  output  1  high in RUN only
done  output  1  one-cycle pulse when the result becomes valid
sum  output  WIDTH  result; held until the next accepted start
cout  output  1  final carry-out; held like sum
ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE.
  - sum=0, cout=0, ovf=0, done=0, busy=0, ready=1.
  - Internal shift registers, carry flop and bit counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On the clock edge with start=1: load a_sh=a, b_sh=b, carry=cin, cnt=0, clear sum register; go to RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - Full adder inputs are a_sh[0], b_sh[0], carry; outputs s and c.
  - Shift a_sh and b_sh right by 1.
  - Shift s into sum at the MSB (sum <= {s, sum[WIDTH-1:1]}).
  - carry <= c; cnt <= cnt+1.
  - When cnt==WIDTH-1: cout <= c and go to DONE.
- DONE: done=1 for exactly this one cycle; unconditionally go to IDLE.
- Latency:
  - Start accepted at edge 0.
  - RUN occupies cycles 1..WIDTH.
  - done is high in cycle WIDTH+1.
  - ready returns in cycle WIDTH+2.
- start while RUN or DONE: ignored, not queued. Operand inputs are don't-care outside the accepting edge.
- sum and cout:
  - Change only during RUN.
  - Intermediate sum contents during RUN are not valid; consumers use them only at or after done.
- cnt width is clog2(WIDTH)+1. No wrap is reachable.
- WIDTH=1: a single RUN cycle, then DONE.
- Reset asserted mid-RUN: immediate return to reset values. The partial result is discarded and no done pulse is issued.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). Exact for all inputs.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - On the last RUN cycle, ovf <= carry_in_to_msb XOR c.
  - carry_in_to_msb is the carry flop value at that cycle.
  - ovf is held and updated with the same rules as cout; it is cleared on an accepted start and on reset.
- Undefined: ovf is tied to 0 and no extra flop is synthesised. The port remains present.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, start pulse -> done high exactly 9 cycles after the accepting edge; sum=0x7F, cout=0; ready high the following cycle.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Start 0x10+0x20; re-assert start with 0x01+0x01 at cycle 3 of RUN -> ignored. Result sum=0x30, single done pulse. Back-to-back start on the first ready cycle is accepted.
- Start 0xAA+0x55; drop rst_n at cycle 4 of RUN -> outputs immediately at reset values; no done. After release, 0x01+0x02 -> sum=0x03.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> sum=0x80, ovf=1; 0x80+0x80 -> sum=0x00, cout=1, ovf=1; 0x10+0x10 -> ovf=0. Without the macro, ovf stays 0 for all three.
- WIDTH=1 build: exhaustive a, b, cin (8 cases) -> {cout, sum}=a+b+cin; done 2 cycles after start.
